// File: rtl/reset_seq_pkg.sv
// Shared state encoding and stage codes for the staged reset controller.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_SDRAM,
    S_WAIT_CAM,
    S_WAIT_DISP,
    S_RUN,
    S_FAULT
  } seq_state_e;

  localparam logic [1:0] STG_NONE  = 2'd0;
  localparam logic [1:0] STG_SDRAM = 2'd1;
  localparam logic [1:0] STG_CAM   = 2'd2;
  localparam logic [1:0] STG_DISP  = 2'd3;

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter with a terminal-count equality compare.
module seq_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk_100,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100) begin
    if (!rst_n || clr)
      cnt <= '0;
    else if (en && cnt != '1)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Releases SDRAM, camera-config and display resets in order, each gated on the
// previous stage reporting ready; retries the whole sequence on timeout, then faults.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYC    = 100,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 32
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       sdram_init_done,
  input  logic       cam_cfg_done,
  input  logic       disp_ready,
  output logic       rst_sdram_n,
  output logic       rst_cam_n,
  output logic       rst_disp_n,
  output logic       sys_ready,
  output logic       fault,
  output logic [1:0] fault_stage,
  output logic [1:0] retry_cnt
);

  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

  seq_state_e state, nxt;
  logic [1:0] fs_nxt, rc_nxt, fail_stg;
  logic       fail, clr, en, tc;
  logic [CNT_W-1:0] tc_val;

  assign tc_val = (state == S_HOLD) ? HOLD_TC : TO_TC;
  assign en     = (state != S_RUN) && (state != S_FAULT);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (en),
    .tc_val  (tc_val),
    .tc      (tc)
  );

  always_comb begin
    nxt      = state;
    fs_nxt   = fault_stage;
    rc_nxt   = retry_cnt;
    fail     = 1'b0;
    fail_stg = STG_NONE;
    clr      = 1'b0;
    if (soft_rst_req) begin
      nxt    = S_HOLD;
      fs_nxt = STG_NONE;
      rc_nxt = 2'd0;
      clr    = 1'b1;
    end else begin
      // Ready is tested before timeout so a ready on the terminal cycle still wins.
      unique case (state)
        S_HOLD:       if (tc) nxt = S_WAIT_SDRAM;
        S_WAIT_SDRAM: if (sdram_init_done) nxt = S_WAIT_CAM;
                      else if (tc) begin fail = 1'b1; fail_stg = STG_SDRAM; end
        S_WAIT_CAM:   if (cam_cfg_done) nxt = S_WAIT_DISP;
                      else if (tc) begin fail = 1'b1; fail_stg = STG_CAM; end
        S_WAIT_DISP:  if (disp_ready) nxt = S_RUN;
                      else if (tc) begin fail = 1'b1; fail_stg = STG_DISP; end
        S_RUN: begin
          fail = !(sdram_init_done && cam_cfg_done && disp_ready);
          if (!sdram_init_done)   fail_stg = STG_SDRAM;
          else if (!cam_cfg_done) fail_stg = STG_CAM;
          else if (!disp_ready)   fail_stg = STG_DISP;
        end
        S_FAULT: ;
        default: nxt = S_HOLD;
      endcase
      if (fail) begin
        fs_nxt = fail_stg;
        rc_nxt = retry_cnt + 2'd1;
        nxt    = (rc_nxt == RETRY_LIM) ? S_FAULT : S_HOLD;
      end
      if (nxt != state) clr = 1'b1;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      state       <= S_HOLD;
      rst_sdram_n <= 1'b0;
      rst_cam_n   <= 1'b0;
      rst_disp_n  <= 1'b0;
      sys_ready   <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= STG_NONE;
      retry_cnt   <= 2'd0;
    end else begin
      state       <= nxt;
      rst_sdram_n <= nxt inside {S_WAIT_SDRAM, S_WAIT_CAM, S_WAIT_DISP, S_RUN};
      rst_cam_n   <= nxt inside {S_WAIT_CAM, S_WAIT_DISP, S_RUN};
      rst_disp_n  <= nxt inside {S_WAIT_DISP, S_RUN};
      sys_ready   <= (nxt == S_RUN);
      fault       <= (nxt == S_FAULT);
      fault_stage <= fs_nxt;
      retry_cnt   <= rc_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences, then random
// stimulus checked against a phase/elapsed-cycle reference model.
module tb_reset_sequencer;

  localparam int HOLD = 4, TO = 16, MR = 2;

  logic clk_100 = 1'b0;
  logic rst_n, soft_rst_req, sdram_init_done, cam_cfg_done, disp_ready;
  logic rst_sdram_n, rst_cam_n, rst_disp_n, sys_ready, fault;
  logic [1:0] fault_stage, retry_cnt;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TO), .MAX_RETRY(MR), .CNT_W(32)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .soft_rst_req(soft_rst_req),
    .sdram_init_done(sdram_init_done), .cam_cfg_done(cam_cfg_done), .disp_ready(disp_ready),
    .rst_sdram_n(rst_sdram_n), .rst_cam_n(rst_cam_n), .rst_disp_n(rst_disp_n),
    .sys_ready(sys_ready), .fault(fault), .fault_stage(fault_stage), .retry_cnt(retry_cnt)
  );

  always #5 clk_100 = ~clk_100;

  // Reference model: ph 0 hold, 1..3 waiting on stage ph, 4 run, 5 fault.
  int m_ph = 0, m_el = 0, m_fs = 0, m_rc = 0;

  task automatic model_fail(input int s);
    m_fs = s;
    m_rc = m_rc + 1;
    m_ph = (m_rc == MR) ? 5 : 0;
    m_el = 0;
  endtask

  task automatic model_step();
    logic [2:0] rdy;
    rdy = {disp_ready, cam_cfg_done, sdram_init_done};
    if (!rst_n) begin
      m_ph = 0; m_el = 0; m_fs = 0; m_rc = 0;
    end else if (soft_rst_req) begin
      m_ph = 0; m_el = 0; m_fs = 0; m_rc = 0;
    end else if (m_ph == 0) begin
      if (m_el == HOLD - 1) begin m_ph = 1; m_el = 0; end
      else m_el++;
    end else if (m_ph >= 1 && m_ph <= 3) begin
      if (rdy[m_ph-1]) begin m_ph++; m_el = 0; end
      else if (m_el == TO - 1) model_fail(m_ph);
      else m_el++;
    end else if (m_ph == 4) begin
      if (!rdy[0]) model_fail(1);
      else if (!rdy[1]) model_fail(2);
      else if (!rdy[2]) model_fail(3);
    end
  endtask

  function automatic logic [8:0] model_out();
    logic [8:0] o;
    o[8]   = (m_ph >= 1 && m_ph <= 4);
    o[7]   = (m_ph >= 2 && m_ph <= 4);
    o[6]   = (m_ph >= 3 && m_ph <= 4);
    o[5]   = (m_ph == 4);
    o[4]   = (m_ph == 5);
    o[3:2] = 2'(m_fs);
    o[1:0] = 2'(m_rc);
    return o;
  endfunction

  function automatic logic [8:0] act();
    return {rst_sdram_n, rst_cam_n, rst_disp_n, sys_ready, fault, fault_stage, retry_cnt};
  endfunction

  task automatic chk(input string name, input logic [8:0] exp);
    checks++;
    if (act() !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (sdram cam disp rdy fault fs rc)", name, act(), exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic a, input logic b, input logic c);
    rst_n = r; soft_rst_req = s; sdram_init_done = a; cam_cfg_done = b; disp_ready = c;
    model_step();
    @(posedge clk_100); #1;
  endtask

  task automatic run_n(input int n, input logic r, input logic s,
                       input logic a, input logic b, input logic c);
    for (int i = 0; i < n; i++) cyc(r, s, a, b, c);
  endtask

  typedef struct {
    string      name;
    int         n;
    logic       r, s, a, b, c;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input string nm, input int n, input logic r, input logic s,
                      input logic a, input logic b, input logic c, input logic [8:0] e);
    vec_t v;
    v.name = nm; v.n = n; v.r = r; v.s = s; v.a = a; v.b = b; v.c = c; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; soft_rst_req = 1'b0;
    sdram_init_done = 1'b0; cam_cfg_done = 1'b0; disp_ready = 1'b0;

    // Nominal bring-up, each done raised 3 cycles after its reset releases.
    addv("reset_state",   2, 0, 0, 0, 0, 0, 9'b000_0_0_00_00);
    addv("hold_edge3",    3, 1, 0, 0, 0, 0, 9'b000_0_0_00_00);
    addv("sdram_edge4",   1, 1, 0, 0, 0, 0, 9'b100_0_0_00_00);
    addv("wait_sdram",    3, 1, 0, 0, 0, 0, 9'b100_0_0_00_00);
    addv("cam_edge8",     1, 1, 0, 1, 0, 0, 9'b110_0_0_00_00);
    addv("wait_cam",      3, 1, 0, 1, 0, 0, 9'b110_0_0_00_00);
    addv("disp_edge12",   1, 1, 0, 1, 1, 0, 9'b111_0_0_00_00);
    addv("wait_disp",     3, 1, 0, 1, 1, 0, 9'b111_0_0_00_00);
    addv("run_edge16",    1, 1, 0, 1, 1, 1, 9'b111_1_0_00_00);
    addv("run_hold",      5, 1, 0, 1, 1, 1, 9'b111_1_0_00_00);
    addv("run_disp_loss", 1, 1, 0, 1, 1, 0, 9'b000_0_0_11_01);
    foreach (tbl[i]) begin
      run_n(tbl[i].n, tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c);
      chk(tbl[i].name, tbl[i].exp);
    end

    // Camera timeout once, then a good pass.
    cyc(0, 0, 0, 0, 0);
    run_n(4, 1, 0, 1, 0, 1);   chk("ct_sdram",   9'b100_0_0_00_00);
    run_n(1, 1, 0, 1, 0, 1);   chk("ct_cam",     9'b110_0_0_00_00);
    run_n(15, 1, 0, 1, 0, 1);  chk("ct_pre_to",  9'b110_0_0_00_00);
    run_n(1, 1, 0, 1, 0, 1);   chk("ct_timeout", 9'b000_0_0_10_01);
    run_n(4, 1, 0, 1, 1, 1);   chk("ct_rehold",  9'b100_0_0_10_01);
    run_n(3, 1, 0, 1, 1, 1);   chk("ct_run",     9'b111_1_0_10_01);

    // SDRAM stuck: two timeouts lead to a latched fault.
    cyc(0, 0, 0, 0, 0);
    run_n(4, 1, 0, 0, 1, 1);   chk("st_sdram",   9'b100_0_0_00_00);
    run_n(15, 1, 0, 0, 1, 1);  chk("st_pre_to",  9'b100_0_0_00_00);
    run_n(1, 1, 0, 0, 1, 1);   chk("st_to1",     9'b000_0_0_01_01);
    run_n(4, 1, 0, 0, 1, 1);   chk("st_retry",   9'b100_0_0_01_01);
    run_n(16, 1, 0, 0, 1, 1);  chk("st_fault",   9'b000_0_1_01_10);
    run_n(50, 1, 0, 1, 1, 1);  chk("st_latched", 9'b000_0_1_01_10);

    // Recovery from fault via soft reset.
    run_n(1, 1, 1, 1, 1, 1);   chk("rc_soft",    9'b000_0_0_00_00);
    run_n(6, 1, 0, 1, 1, 1);   chk("rc_disp",    9'b111_0_0_00_00);
    run_n(1, 1, 0, 1, 1, 1);   chk("rc_run",     9'b111_1_0_00_00);

    // Simultaneous events.
    cyc(0, 0, 0, 0, 0);
    run_n(4, 1, 0, 0, 0, 0);
    run_n(15, 1, 0, 0, 0, 0);  chk("sim_pre_to", 9'b100_0_0_00_00);
    run_n(1, 1, 0, 1, 0, 0);   chk("sim_rdy_to", 9'b110_0_0_00_00);
    run_n(15, 1, 0, 1, 0, 0);
    run_n(1, 1, 1, 1, 0, 0);   chk("sim_soft_to", 9'b000_0_0_00_00);
    run_n(2, 1, 0, 1, 0, 0);
    run_n(1, 1, 1, 1, 0, 0);
    run_n(3, 1, 0, 1, 0, 0);   chk("hold_restart", 9'b000_0_0_00_00);
    run_n(1, 1, 0, 1, 0, 0);   chk("hold_release", 9'b100_0_0_00_00);
    run_n(1, 1, 0, 1, 0, 0);
    run_n(16, 1, 0, 1, 0, 0);  chk("cam_to",      9'b000_0_0_10_01);
    run_n(5, 1, 0, 1, 0, 0);
    run_n(3, 1, 0, 1, 0, 0);   chk("mid_cam",     9'b110_0_0_10_01);
    run_n(1, 0, 0, 1, 0, 0);   chk("rst_mid_cam", 9'b000_0_0_00_00);

    // Random stimulus against the reference model; stuck masks force timeouts.
    begin
      logic [2:0] stuck;
      logic r, s;
      logic [2:0] d;
      stuck = 3'b000;
      for (int i = 0; i < 4000; i++) begin
        if (i % 150 == 0) stuck = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
        r = ($urandom_range(0, 299) != 0);
        s = ($urandom_range(0, 199) == 0);
        for (int k = 0; k < 3; k++) d[k] = !stuck[k] && ($urandom_range(0, 15) != 0);
        cyc(r, s, d[0], d[1], d[2]);
        chk("random", model_out());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
